// File: rtl/icache_req_sched.sv
// icache_req_sched: arbitrates CPU fetch, whole-cache invalidate and prefetch onto one
// registered issue slot. Define ICACHE_REQ_SCHED_PERF_EN to add 32-bit grant counters.
module icache_req_sched #(
    parameter int ADDR_W       = 32,
    parameter int SET_W        = 6,
    parameter int OFF_W        = 6,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    input  logic              inv_req_valid,
    output logic              inv_req_ready,
    input  logic              pf_req_valid,
    input  logic [ADDR_W-1:0] pf_req_addr,
    output logic              pf_req_ready,
    output logic              out_valid,
    output logic [1:0]        out_op,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              inv_busy,
    output logic              inv_done
`ifdef ICACHE_REQ_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cpu_grants,
    output logic [31:0]       perf_pf_grants,
    output logic [31:0]       perf_pf_forced
`endif
);

    // state     | meaning
    // IDLE      | arbitrate CPU / prefetch, accept invalidate
    // INV_WALK  | issue one invalidate-set op per free slot cycle
    // INV_DRAIN | last set issued, wait for the slot to empty
    // INV_DONE  | pulse inv_done, then return to IDLE
    typedef enum logic [1:0] {IDLE, INV_WALK, INV_DRAIN, INV_DONE} state_t;

    localparam int         NUM_SETS = 2 ** SET_W;
    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_PF    = 2'b01;
    localparam logic [1:0] OP_INV   = 2'b10;

    state_t              state_q, state_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [1:0]          out_op_q, out_op_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

    logic                slot_free;
    logic                starve_hit;
    logic                starve_sat;
    logic                cpu_gnt;
    logic                pf_gnt;
    logic                pf_forced;
    logic                load;
    logic [1:0]          load_op;
    logic [ADDR_W-1:0]   load_addr;
    logic [ADDR_W-1:0]   set_addr;

    assign slot_free  = !out_valid_q || out_ready;
    assign starve_hit = starve_cnt_q >= CNT_W'(STARVE_LIMIT);
    assign starve_sat = &starve_cnt_q;
    assign set_addr   = {{(ADDR_W-SET_W-OFF_W){1'b0}}, set_cnt_q, {OFF_W{1'b0}}};

    always_comb begin
        state_d      = state_q;
        set_cnt_d    = set_cnt_q;
        starve_cnt_d = starve_cnt_q;
        cpu_gnt      = 1'b0;
        pf_gnt       = 1'b0;
        pf_forced    = 1'b0;
        load         = 1'b0;
        load_op      = OP_FETCH;
        load_addr    = '0;

        case (state_q)
            IDLE: begin
                if (inv_req_valid) begin
                    state_d   = INV_WALK;
                    set_cnt_d = '0;
                end else if (slot_free) begin
                    if (pf_req_valid && starve_hit) begin
                        pf_gnt    = 1'b1;
                        pf_forced = 1'b1;
                    end else if (cpu_req_valid) begin
                        cpu_gnt = 1'b1;
                    end else if (pf_req_valid) begin
                        pf_gnt = 1'b1;
                    end
                end

                // only a CPU win over a waiting prefetch counts as a lost cycle
                if (!pf_req_valid || pf_gnt) begin
                    starve_cnt_d = '0;
                end else if (cpu_gnt && !starve_sat) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end

                if (cpu_gnt) begin
                    load      = 1'b1;
                    load_op   = OP_FETCH;
                    load_addr = cpu_req_addr;
                end else if (pf_gnt) begin
                    load      = 1'b1;
                    load_op   = OP_PF;
                    load_addr = pf_req_addr;
                end
            end
            INV_WALK: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_op   = OP_INV;
                    load_addr = set_addr;
                    set_cnt_d = set_cnt_q + 1'b1;
                    if (set_cnt_q == SET_W'(NUM_SETS - 1)) begin
                        state_d = INV_DRAIN;
                    end
                end
            end
            INV_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = INV_DONE;
                end
            end
            INV_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = load || (out_valid_q && !out_ready);
        out_op_d    = load ? load_op : out_op_q;
        out_addr_d  = load ? load_addr : out_addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            set_cnt_q    <= '0;
            starve_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            out_valid_q  <= out_valid_d;
            out_op_q     <= out_op_d;
            out_addr_q   <= out_addr_d;
        end
    end

    // readies are combinational; masking with reset keeps them low while reset is held
    assign inv_req_ready = (state_q == IDLE) && !reset;
    assign cpu_req_ready = cpu_gnt && !reset;
    assign pf_req_ready  = pf_gnt && !reset;
    assign out_valid     = out_valid_q;
    assign out_op        = out_op_q;
    assign out_addr      = out_addr_q;
    assign inv_busy      = (state_q != IDLE);
    assign inv_done      = (state_q == INV_DONE);

`ifdef ICACHE_REQ_SCHED_PERF_EN
    logic [31:0] perf_cpu_q, perf_cpu_d;
    logic [31:0] perf_pf_q, perf_pf_d;
    logic [31:0] perf_forced_q, perf_forced_d;

    always_comb begin
        perf_cpu_d    = perf_cpu_q + {31'd0, cpu_gnt};
        perf_pf_d     = perf_pf_q + {31'd0, pf_gnt};
        perf_forced_d = perf_forced_q + {31'd0, pf_forced};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cpu_q    <= '0;
            perf_pf_q     <= '0;
            perf_forced_q <= '0;
        end else begin
            perf_cpu_q    <= perf_cpu_d;
            perf_pf_q     <= perf_pf_d;
            perf_forced_q <= perf_forced_d;
        end
    end

    assign perf_cpu_grants = perf_cpu_q;
    assign perf_pf_grants  = perf_pf_q;
    assign perf_pf_forced  = perf_forced_q;
`endif

endmodule

// File: tb/tb_icache_req_sched.sv
// Bench for icache_req_sched: vector table, directed invalidate/stall/reset sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_icache_req_sched;
    localparam int ADDR_W       = 32;
    localparam int SET_W        = 6;
    localparam int OFF_W        = 6;
    localparam int STARVE_LIMIT = 8;
    localparam int CNT_W        = 4;
    localparam int NUM_SETS     = 64;
    localparam int STARVE_MAX   = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req_valid;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_ready;
    logic              inv_req_valid;
    logic              inv_req_ready;
    logic              pf_req_valid;
    logic [ADDR_W-1:0] pf_req_addr;
    logic              pf_req_ready;
    logic              out_valid;
    logic [1:0]        out_op;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;
    logic              inv_busy;
    logic              inv_done;
`ifdef ICACHE_REQ_SCHED_PERF_EN
    logic [31:0]       perf_cpu_grants;
    logic [31:0]       perf_pf_grants;
    logic [31:0]       perf_pf_forced;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_req_sched #(
        .ADDR_W(ADDR_W), .SET_W(SET_W), .OFF_W(OFF_W),
        .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .inv_req_valid(inv_req_valid), .inv_req_ready(inv_req_ready),
        .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
        .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr), .out_ready(out_ready),
        .inv_busy(inv_busy), .inv_done(inv_done)
`ifdef ICACHE_REQ_SCHED_PERF_EN
        , .perf_cpu_grants(perf_cpu_grants), .perf_pf_grants(perf_pf_grants),
        .perf_pf_forced(perf_pf_forced)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic        m_ov;
    logic [1:0]  m_op;
    logic [31:0] m_addr;
    int          m_starve;
    int          m_mode;          // 0 arbitrating, 1 invalidate in progress, 2 done pulse
    logic [31:0] m_pend[$];       // invalidate ops not yet issued
    int          m_cpu_cnt, m_pf_cnt, m_forced_cnt;

    task automatic model_reset();
        m_ov = 1'b0; m_op = 2'b00; m_addr = '0; m_starve = 0; m_mode = 0;
        m_pend.delete();
        m_cpu_cnt = 0; m_pf_cnt = 0; m_forced_cnt = 0;
    endtask

    task automatic model_cycle();
        bit free, g_cpu, g_pf, forced, acc;
        free = !m_ov || out_ready;
        g_cpu = 0; g_pf = 0; forced = 0; acc = 0;
        if (m_mode == 0) begin
            if (inv_req_valid) acc = 1;
            else if (free) begin
                if (pf_req_valid && m_starve >= STARVE_LIMIT) begin g_pf = 1; forced = 1; end
                else if (cpu_req_valid) g_cpu = 1;
                else if (pf_req_valid) g_pf = 1;
            end
        end

        check("rnd cpu_req_ready", cpu_req_ready, g_cpu);
        check("rnd pf_req_ready", pf_req_ready, g_pf);
        check("rnd inv_req_ready", inv_req_ready, m_mode == 0);
        check("rnd out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("rnd out_op", out_op, m_op);
            check("rnd out_addr", out_addr, m_addr);
        end
        check("rnd inv_busy", inv_busy, m_mode != 0);
        check("rnd inv_done", inv_done, m_mode == 2);

        m_cpu_cnt += g_cpu;
        m_pf_cnt += g_pf;
        m_forced_cnt += forced;

        case (m_mode)
            0: begin
                if (!pf_req_valid || g_pf) m_starve = 0;
                else if (g_cpu) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
                if (g_cpu) begin m_ov = 1; m_op = 2'b00; m_addr = cpu_req_addr; end
                else if (g_pf) begin m_ov = 1; m_op = 2'b01; m_addr = pf_req_addr; end
                else if (out_ready) m_ov = 0;
                if (acc) begin
                    for (int s = 0; s < NUM_SETS; s++) m_pend.push_back(32'(s) << OFF_W);
                    m_mode = 1;
                end
            end
            1: begin
                if (m_pend.size() > 0) begin
                    if (free) begin m_ov = 1; m_op = 2'b10; m_addr = m_pend.pop_front(); end
                end else if (free) begin
                    m_ov = 0;
                    m_mode = 2;
                end
            end
            default: begin
                if (out_ready) m_ov = 0;
                m_mode = 0;
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        cpu_req_valid = 0; cpu_req_addr = '0; inv_req_valid = 0;
        pf_req_valid = 0; pf_req_addr = '0; out_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        cpu_v;
        logic [31:0] cpu_a;
        logic        pf_v;
        logic [31:0] pf_a;
        logic        o_rdy;
        logic        e_cpu;
        logic        e_pf;
        logic        e_ov;
        logic [1:0]  e_op;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int leak, done_cnt, stall, bad, dones;
        bit seen280, finished, found;
        logic [31:0] got_addr[$];
        logic [1:0]  got_op[$];

        // ---- reset state ----
        reset = 1'b1;
        clear_inputs();
        cpu_req_valid = 1; pf_req_valid = 1; out_ready = 1;
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset out_op", out_op, 0);
        check("reset out_addr", out_addr, 0);
        check("reset inv_busy", inv_busy, 0);
        check("reset inv_done", inv_done, 0);
        check("reset cpu_req_ready", cpu_req_ready, 0);
        check("reset pf_req_ready", pf_req_ready, 0);
        check("reset inv_req_ready", inv_req_ready, 0);

        // ---- vector table ----
        vecs[0] = '{1'b1, 32'h1000, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h1000};
        vecs[1] = '{1'b0, 32'h0,    1'b1, 32'h2040, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h2040};
        vecs[2] = '{1'b1, 32'h3000, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h2040};
        vecs[3] = '{1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h3000};
        vecs[4] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[5] = '{1'b0, 32'h0,    1'b1, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h5000};
        vecs[6] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h5000};
        vecs[7] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cpu_req_valid = vecs[i].cpu_v; cpu_req_addr = vecs[i].cpu_a;
            pf_req_valid = vecs[i].pf_v; pf_req_addr = vecs[i].pf_a;
            out_ready = vecs[i].o_rdy;
            #1;
            check($sformatf("vec%0d cpu_req_ready", i), cpu_req_ready, vecs[i].e_cpu);
            check($sformatf("vec%0d pf_req_ready", i), pf_req_ready, vecs[i].e_pf);
            check($sformatf("vec%0d inv_req_ready", i), inv_req_ready, 1);
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d out_op", i), out_op, vecs[i].e_op);
                check($sformatf("vec%0d out_addr", i), out_addr, vecs[i].e_addr);
            end
        end

        // ---- starvation: 8 CPU grants, then one forced prefetch ----
        do_reset();
        cpu_req_valid = 1; cpu_req_addr = 32'h0100; pf_req_valid = 1; pf_req_addr = 32'h0200;
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("starve cyc%0d cpu_req_ready", i), cpu_req_ready, !(i == 8 || i == 17));
            check($sformatf("starve cyc%0d pf_req_ready", i), pf_req_ready, (i == 8 || i == 17));
            tick();
        end
`ifdef ICACHE_REQ_SCHED_PERF_EN
        check("perf_cpu_grants after starve", perf_cpu_grants, 18);
        check("perf_pf_grants after starve", perf_pf_grants, 2);
        check("perf_pf_forced after starve", perf_pf_forced, 2);
`endif

        // ---- hold slot, then back-to-back load ----
        do_reset();
        cpu_req_valid = 1; cpu_req_addr = 32'h1000; out_ready = 0;
        #1;
        check("hold first grant", cpu_req_ready, 1);
        tick();
        cpu_req_addr = 32'h1040;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold cpu_req_ready", cpu_req_ready, 0);
            check("hold out_valid", out_valid, 1);
            check("hold out_addr", out_addr, 32'h1000);
            tick();
        end
        out_ready = 1;
        #1;
        check("hold back-to-back grant", cpu_req_ready, 1);
        tick();
        check("hold next out_valid", out_valid, 1);
        check("hold next out_addr", out_addr, 32'h1040);

        // ---- full invalidate walk with a 5-cycle stall at set 10 ----
        do_reset();
        cpu_req_valid = 1; cpu_req_addr = 32'h7000; inv_req_valid = 1; out_ready = 1;
        #1;
        check("inv accept inv_req_ready", inv_req_ready, 1);
        check("inv accept cpu_req_ready", cpu_req_ready, 0);
        tick();
        inv_req_valid = 0;
        check("inv busy after accept", inv_busy, 1);
        leak = 0; done_cnt = 0; stall = 0; seen280 = 0; finished = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (!seen280 && out_valid && out_addr == 32'h280) begin seen280 = 1; stall = 5; end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                check("stall out_addr", out_addr, 32'h280);
                stall--;
            end
            if (inv_busy && (cpu_req_ready || pf_req_ready || inv_req_ready)) leak++;
            if (out_valid && out_ready) begin got_addr.push_back(out_addr); got_op.push_back(out_op); end
            if (inv_done) begin done_cnt++; finished = 1; end
            tick();
        end
        check("inv walk completed", finished, 1);
        check("inv stall seen", seen280, 1);
        check("inv no grants while busy", leak, 0);
        check("inv op count", got_addr.size(), NUM_SETS);
        bad = 0;
        for (int k = 0; k < got_addr.size(); k++) begin
            if (got_op[k] !== 2'b10 || got_addr[k] !== (32'(k) << OFF_W)) bad++;
        end
        check("inv op sequence mismatches", bad, 0);
        check("inv_done pulses", done_cnt, 1);
        #1;
        check("inv_done one cycle", inv_done, 0);
        check("inv busy cleared", inv_busy, 0);
        check("cpu granted after walk", cpu_req_ready, 1);
        tick();
        check("post-walk out_op", out_op, 2'b00);
        check("post-walk out_addr", out_addr, 32'h7000);

        // ---- reset mid-walk at set 30, all three sources valid at accept ----
        do_reset();
        cpu_req_valid = 1; cpu_req_addr = 32'h9000; pf_req_valid = 1; pf_req_addr = 32'hA000;
        inv_req_valid = 1; out_ready = 1;
        #1;
        check("all3 inv_req_ready", inv_req_ready, 1);
        check("all3 cpu_req_ready", cpu_req_ready, 0);
        check("all3 pf_req_ready", pf_req_ready, 0);
        tick();
        inv_req_valid = 0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (out_valid && out_addr == (32'd30 << OFF_W)) found = 1;
            else tick();
        end
        check("reached set 30", found, 1);
        reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_op", out_op, 0);
        check("midreset out_addr", out_addr, 0);
        check("midreset inv_busy", inv_busy, 0);
        check("midreset cpu_req_ready", cpu_req_ready, 0);
        check("midreset inv_req_ready", inv_req_ready, 0);
        dones = inv_done;
        repeat (3) begin tick(); dones += inv_done; end
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            dones += inv_done;
            if (c == 0) begin
                check("after midreset idle inv_req_ready", inv_req_ready, 1);
                check("after midreset cpu_req_ready", cpu_req_ready, 1);
            end
            tick();
        end
        check("midreset no inv_done", dones, 0);

        // ---- randomized traffic vs. model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cpu_req_valid = ($urandom_range(0, 9) < 7);
            cpu_req_addr  = $urandom;
            pf_req_valid  = ($urandom_range(0, 9) < 6);
            pf_req_addr   = $urandom;
            inv_req_valid = ($urandom_range(0, 149) == 0);
            out_ready     = ($urandom_range(0, 9) < 7);
            #1;
            model_cycle();
            tick();
        end
`ifdef ICACHE_REQ_SCHED_PERF_EN
        check("rnd perf_cpu_grants", perf_cpu_grants, m_cpu_cnt);
        check("rnd perf_pf_grants", perf_pf_grants, m_pf_cnt);
        check("rnd perf_pf_forced", perf_pf_forced, m_forced_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_req_sched.md
Name: icache_req_sched

Overview:
- Schedules the three icache request sources onto the single icache pipeline input: CPU fetch, whole-cache invalidate and prefetch.
- Output goes through a one-entry registered slot with valid/ready handshake.
- Priority order is invalidate > CPU > prefetch, with a starvation guard for prefetch.
- An accepted invalidate is expanded into a per-set walk that blocks fetch traffic until it completes.

Parameters:
- ADDR_W, 32, fetch address width.
- SET_W, 6, set index width; NUM_SETS = 2**SET_W.
- OFF_W, 6, line offset width; set index sits at addr[OFF_W+SET_W-1:OFF_W].
- STARVE_LIMIT, 8, consecutive lost cycles after which prefetch overrides CPU.
- CNT_W, 4, starvation counter width; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- cpu_req_valid, input, 1, CPU fetch request.
- cpu_req_addr, input, ADDR_W, CPU fetch address.
- cpu_req_ready, output, 1, CPU request accepted this cycle.
- inv_req_valid, input, 1, whole-cache invalidate request.
- inv_req_ready, output, 1, invalidate accepted this cycle.
- pf_req_valid, input, 1, prefetch request.
- pf_req_addr, input, ADDR_W, prefetch address.
- pf_req_ready, output, 1, prefetch accepted this cycle.
- out_valid, output, 1, output slot holds an op.
- out_op, output, 2, op code: 00 = fetch, 01 = prefetch, 10 = invalidate set.
- out_addr, output, ADDR_W, op address; for invalidate, the set index at the set bits and zero elsewhere.
- out_ready, input, 1, pipeline accepts the slot.
- inv_busy, output, 1, high whenever state != IDLE.
- inv_done, output, 1, one-cycle pulse at the end of the invalidate walk.

Behaviour:
- Reset is asynchronous on clk, active-high (named reset). Reset clears:
  - state to IDLE, out_valid, out_op, out_addr, set_cnt, starve_cnt.
  - inv_done, inv_busy and all readies to 0.
- Reset mid-walk abandons the walk; no inv_done is generated.
- Slot free condition: slot_free = !out_valid || out_ready. A slot load and a drain may occur in the same cycle.
- FSM states: IDLE, INV_WALK, INV_DRAIN, INV_DONE.
- IDLE:
  - inv_req_ready = 1.
  - When inv_req_valid is high: accept, go to INV_WALK with set_cnt = 0. No CPU or prefetch grant in that cycle.
  - Otherwise, if slot_free, grant one source:
    - Prefetch wins if pf_req_valid and starve_cnt >= STARVE_LIMIT.
    - Else CPU wins if cpu_req_valid.
    - Else prefetch wins if pf_req_valid.
  - The granted source's ready is 1 combinationally.
  - The slot loads {op, addr} on the next edge; latency is 1 cycle from accept to out_valid.
- INV_WALK:
  - cpu_req_ready = pf_req_ready = inv_req_ready = 0.
  - Each cycle with slot_free: load op = 10, addr = set_cnt << OFF_W, then increment set_cnt.
  - After loading set NUM_SETS-1, go to INV_DRAIN.
- INV_DRAIN: wait until the last op drains (out_valid && out_ready, or out_valid already 0), then go to INV_DONE.
- INV_DONE: inv_done = 1 for exactly one cycle, then go to IDLE. A new invalidate is accepted from IDLE one cycle later.
- starve_cnt:
  - Increments (saturating at 2**CNT_W-1) each cycle pf_req_valid is high and the CPU is granted.
  - Clears when prefetch is granted or pf_req_valid is low.
  - Holds during the invalidate states.
- Holding the slot:
  - out_valid holds with stable out_op/out_addr until out_ready.
  - No source is granted while out_valid && !out_ready.
- Simultaneous valid on all three sources in IDLE: invalidate wins; CPU and prefetch stay pending.

Optional Feature:
- Macro: ICACHE_REQ_SCHED_PERF_EN.
- When defined, three extra 32-bit output ports exist: perf_cpu_grants, perf_pf_grants, perf_pf_forced.
  - They count CPU grants, prefetch grants, and prefetch grants won via the starvation override.
  - They wrap on overflow and are cleared by reset.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CPU only, addr 0x1000, out_ready=1 -> cpu_req_ready=1 same cycle; next cycle out_valid=1, out_op=00, out_addr=0x1000.
- CPU and prefetch valid continuously, out_ready=1 -> 8 CPU grants, then 1 prefetch grant (perf_pf_forced=1), then CPU grants resume.
- inv_req_valid with CPU valid, out_ready=1 -> inv accepted, inv_busy=1; 64 ops with op=10 and addr 0x000..0xFC0 step 0x40; inv_done pulses once; CPU is then granted.
- During the walk, hold out_ready=0 for 5 cycles at set 10 -> out_addr stays 0x280 and set_cnt is stable; the walk resumes at set 11.
- Assert reset mid-walk at set 30 -> all outputs 0 immediately, state IDLE, no inv_done.
- out_valid=1 with out_ready=0 and CPU valid -> cpu_req_ready=0 until out_ready=1, then a back-to-back load in the same cycle.
